// File: rtl/sparse_stream_decoder.sv
// rtl/sparse_stream_decoder.sv - raw compressed activation stream to decoded token stream
// Tracks row/column position, flags malformed streams and ends each stream with a sync token.
module sparse_stream_decoder #(
   parameter int STREAM_WORD_WIDTH       = 16,
   parameter int ACTIVATION_BIT_WIDTH    = 8,
   parameter int CHANNEL_VALUE_BIT_WIDTH = 6,
   parameter int COLUMN_VALUE_BIT_WIDTH  = 8,
   parameter int ROW_VALUE_BIT_WIDTH     = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_start,
   input  logic [CHANNEL_VALUE_BIT_WIDTH:0]   i_num_channels,
   input  logic [COLUMN_VALUE_BIT_WIDTH:0]    i_num_columns,
   input  logic [STREAM_WORD_WIDTH-1:0]       i_stream_data,
   input  logic                               i_stream_valid,
   output logic                               o_stream_ready,
   output logic [ACTIVATION_BIT_WIDTH-1:0]    o_data,
   output logic [CHANNEL_VALUE_BIT_WIDTH-1:0] o_channel,
   output logic [ROW_VALUE_BIT_WIDTH-1:0]     o_relative_row,
   output logic                               o_toggled_column,
   output logic                               o_last_column,
   output logic                               o_sync,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic                               o_error,
   output logic                               o_busy
);

   localparam int ACT_W = ACTIVATION_BIT_WIDTH;
   localparam int CH_W  = CHANNEL_VALUE_BIT_WIDTH;
   localparam int COL_W = COLUMN_VALUE_BIT_WIDTH;
   localparam int ROW_W = ROW_VALUE_BIT_WIDTH;
   localparam int TOK_W = ACT_W + CH_W + ROW_W + 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] WT_ACT  = 2'b00;
   localparam logic [1:0] WT_COL  = 2'b01;
   localparam logic [1:0] WT_ROW  = 2'b10;
   localparam logic [1:0] WT_SYNC = 2'b11;

   logic [1:0]       state;
   logic [TOK_W-1:0] fifo_mem [0:1];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       fifo_count;

   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic             toggle_q;
   logic             last_q;
   logic             error_q;

   logic [1:0]       word_type;
   logic [CH_W-1:0]  word_channel;
   logic [ACT_W-1:0] word_data;
   logic             accept;
   logic             chan_ok;
   logic             push;
   logic             pop;
   logic             start_ok;
   logic [TOK_W-1:0] push_token;
   logic [TOK_W-1:0] head_token;
   logic [COL_W:0]   col_next;
   logic             col_overflow;
   logic [COL_W-1:0] col_max;

   assign word_type    = i_stream_data[STREAM_WORD_WIDTH-1 -: 2];
   assign word_channel = i_stream_data[ACT_W +: CH_W];
   assign word_data    = i_stream_data[ACT_W-1:0];

   // Ready depends only on registered state so the source never sees a combinational loop.
   assign o_stream_ready = (state == ST_RUN) && (fifo_count < 2'd2);
   assign accept         = i_stream_valid && o_stream_ready;
   assign chan_ok        = {1'b0, word_channel} < i_num_channels;
   assign push           = accept && (((word_type == WT_ACT) && chan_ok) || (word_type == WT_SYNC));
   assign o_valid        = (fifo_count != 2'd0);
   assign pop            = o_valid && i_ready;
   assign start_ok       = i_start && ((state == ST_IDLE) || ((state == ST_DONE) && (fifo_count == 2'd0)));

   assign col_next     = {1'b0, col_q} + {{COL_W{1'b0}}, 1'b1};
   assign col_overflow = (col_next >= i_num_columns);
   assign col_max      = i_num_columns[COL_W-1:0] - {{(COL_W-1){1'b0}}, 1'b1};

   assign push_token = (word_type == WT_SYNC)
                     ? {{ACT_W{1'b0}}, {CH_W{1'b0}}, {ROW_W{1'b0}}, 1'b0, 1'b0, 1'b1}
                     : {word_data, word_channel, row_q, toggle_q, last_q, 1'b0};

   assign head_token = o_valid ? fifo_mem[rd_ptr] : {TOK_W{1'b0}};

   assign o_data           = head_token[TOK_W-1 -: ACT_W];
   assign o_channel        = head_token[ROW_W+3 +: CH_W];
   assign o_relative_row   = head_token[3 +: ROW_W];
   assign o_toggled_column = head_token[2];
   assign o_last_column    = head_token[1];
   assign o_sync           = head_token[0];
   assign o_error          = error_q;
   assign o_busy           = (state == ST_RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_mem[0] <= {TOK_W{1'b0}};
         fifo_mem[1] <= {TOK_W{1'b0}};
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= push_token;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start_ok) state <= ST_RUN;
            ST_RUN:  if (accept && (word_type == WT_SYNC)) state <= ST_DONE;
            ST_DONE: if (start_ok) state <= ST_RUN;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q    <= {ROW_W{1'b0}};
         col_q    <= {COL_W{1'b0}};
         toggle_q <= 1'b0;
         last_q   <= 1'b0;
      end else if (accept) begin
         case (word_type)
            WT_COL: begin
               toggle_q <= ~toggle_q;
               last_q   <= i_stream_data[0];
               col_q    <= col_overflow ? col_max : col_next[COL_W-1:0];
            end
            WT_ROW: begin
               row_q    <= i_stream_data[ROW_W-1:0];
               col_q    <= {COL_W{1'b0}};
               toggle_q <= 1'b0;
               last_q   <= 1'b0;
            end
            WT_SYNC: begin
               row_q    <= {ROW_W{1'b0}};
               col_q    <= {COL_W{1'b0}};
               toggle_q <= 1'b0;
               last_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Sticky until the next accepted start; decoding carries on regardless.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (start_ok) begin
         error_q <= 1'b0;
      end else if (accept && (((word_type == WT_ACT) && !chan_ok) ||
                              ((word_type == WT_COL) && col_overflow))) begin
         error_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sparse_stream_decoder.sv
// tb/tb_sparse_stream_decoder.sv - directed table-driven bench for sparse_stream_decoder
module tb_sparse_stream_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_start;
   logic [6:0]  i_num_channels;
   logic [8:0]  i_num_columns;
   logic [15:0] i_stream_data;
   logic        i_stream_valid;
   logic        o_stream_ready;
   logic [7:0]  o_data;
   logic [5:0]  o_channel;
   logic [1:0]  o_relative_row;
   logic        o_toggled_column;
   logic        o_last_column;
   logic        o_sync;
   logic        o_valid;
   logic        i_ready;
   logic        o_error;
   logic        o_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sparse_stream_decoder dut (
      .clk              (clk),
      .reset            (reset),
      .i_start          (i_start),
      .i_num_channels   (i_num_channels),
      .i_num_columns    (i_num_columns),
      .i_stream_data    (i_stream_data),
      .i_stream_valid   (i_stream_valid),
      .o_stream_ready   (o_stream_ready),
      .o_data           (o_data),
      .o_channel        (o_channel),
      .o_relative_row   (o_relative_row),
      .o_toggled_column (o_toggled_column),
      .o_last_column    (o_last_column),
      .o_sync           (o_sync),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_error          (o_error),
      .o_busy           (o_busy)
   );

   typedef struct {
      logic [15:0] word;
      logic        exp_valid;
      logic [7:0]  exp_data;
      logic [5:0]  exp_ch;
      logic [1:0]  exp_row;
      logic        exp_tog;
      logic        exp_last;
      logic        exp_err;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Holds the word until accepted; returns one cycle after the accepting edge.
   task automatic send(input logic [15:0] w);
      int n;
      n = 0;
      i_stream_data  = w;
      i_stream_valid = 1'b1;
      while (!o_stream_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_accept_timeout", (n < 20), 1);
      tick();
      i_stream_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] got [4];
      int         n_got;
      logic       accept_now;

      vecs[0] = '{16'h0305, 1'b1, 8'h05, 6'd3, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h8002, 1'b0, 8'h00, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'h4000, 1'b0, 8'h00, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{16'h4001, 1'b0, 8'h00, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{16'h0111, 1'b1, 8'h11, 6'd1, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{16'h4000, 1'b0, 8'h00, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{16'h0722, 1'b1, 8'h22, 6'd7, 2'd2, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{16'h8001, 1'b0, 8'h00, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{16'h0A07, 1'b0, 8'h00, 6'd0, 2'd0, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{16'h0144, 1'b1, 8'h44, 6'd1, 2'd1, 1'b0, 1'b0, 1'b1};

      reset          = 1'b1;
      i_start        = 1'b0;
      i_num_channels = 7'd8;
      i_num_columns  = 9'd8;
      i_stream_data  = 16'h0000;
      i_stream_valid = 1'b0;
      i_ready        = 1'b1;
      #1;
      chk("reset_valid", o_valid, 0);
      chk("reset_ready", o_stream_ready, 0);
      chk("reset_busy", o_busy, 0);
      chk("reset_error", o_error, 0);
      chk("reset_data", o_data, 0);
      chk("reset_sync", o_sync, 0);
      tick();
      reset = 1'b0;
      tick();

      pulse_start();
      chk("start_busy", o_busy, 1);
      chk("start_ready", o_stream_ready, 1);

      for (int i = 0; i < 10; i++) begin
         send(vecs[i].word);
         chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d_error", i), o_error, vecs[i].exp_err);
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_channel", i), o_channel, vecs[i].exp_ch);
            chk($sformatf("vec%0d_row", i), o_relative_row, vecs[i].exp_row);
            chk($sformatf("vec%0d_toggle", i), o_toggled_column, vecs[i].exp_tog);
            chk($sformatf("vec%0d_last", i), o_last_column, vecs[i].exp_last);
            chk($sformatf("vec%0d_sync", i), o_sync, 0);
         end
      end
      tick();

      // Sync token left pending so the DONE-with-nonempty-FIFO start is ignored.
      i_ready = 1'b0;
      send(16'hC000);
      chk("sync_valid", o_valid, 1);
      chk("sync_flag", o_sync, 1);
      chk("sync_data", o_data, 0);
      chk("sync_channel", o_channel, 0);
      chk("done_busy", o_busy, 0);
      chk("done_ready", o_stream_ready, 0);
      pulse_start();
      chk("done_start_ignored_busy", o_busy, 0);
      chk("done_start_ignored_error", o_error, 1);
      i_ready = 1'b1;
      tick();
      chk("sync_popped", o_valid, 0);
      pulse_start();
      chk("restart_busy", o_busy, 1);
      chk("restart_error_cleared", o_error, 0);
      send(16'h0102);
      chk("restart_tok_valid", o_valid, 1);
      chk("restart_tok_data", o_data, 8'h02);
      chk("restart_tok_row", o_relative_row, 0);
      chk("restart_tok_toggle", o_toggled_column, 0);
      chk("restart_tok_last", o_last_column, 0);

      i_num_columns = 9'd2;
      send(16'h4000);
      chk("col1_error", o_error, 0);
      send(16'h4000);
      send(16'h4000);
      chk("col3_error", o_error, 1);
      send(16'h0155);
      chk("col_tok_valid", o_valid, 1);
      chk("col_tok_toggle", o_toggled_column, 1);
      chk("col_tok_data", o_data, 8'h55);

      send(16'hC000);
      tick();
      i_num_channels = 7'd4;
      pulse_start();
      chk("chan_restart_error", o_error, 0);
      send(16'h0309);
      chk("chan3_valid", o_valid, 1);
      chk("chan3_channel", o_channel, 3);
      chk("chan3_error", o_error, 0);
      send(16'h0A07);
      chk("chan10_no_token", o_valid, 0);
      chk("chan10_error", o_error, 1);

      i_ready = 1'b0;
      send(16'h0011);
      send(16'h0022);
      chk("bp_ready_low", o_stream_ready, 0);
      i_stream_data  = 16'h0033;
      i_stream_valid = 1'b1;
      tick();
      tick();
      chk("bp_ready_held_low", o_stream_ready, 0);
      chk("bp_head_stable", o_data, 8'h11);
      i_ready = 1'b1;
      n_got   = 0;
      for (int c = 0; c < 12; c++) begin
         accept_now = i_stream_valid && o_stream_ready;
         if (o_valid) begin
            if (n_got < 4) got[n_got] = o_data;
            n_got++;
         end
         tick();
         if (accept_now) i_stream_valid = 1'b0;
      end
      chk("bp_token_count", n_got, 3);
      chk("bp_tok0", got[0], 8'h11);
      chk("bp_tok1", got[1], 8'h22);
      chk("bp_tok2", got[2], 8'h33);

      i_ready = 1'b0;
      send(16'h0111);
      send(16'h0122);
      chk("pre_reset_full", o_stream_ready, 0);
      chk("pre_reset_valid", o_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_valid", o_valid, 0);
      chk("async_reset_busy", o_busy, 0);
      chk("async_reset_error", o_error, 0);
      tick();
      reset   = 1'b0;
      i_ready = 1'b1;
      tick();
      chk("post_reset_valid", o_valid, 0);
      chk("post_reset_idle", o_busy, 0);
      chk("post_reset_ready", o_stream_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
